// File: rtl/regfile_dump.sv
// regfile_dump: debug read-out engine for the register file.
// On a start pulse it walks the register file read port from FIRST to NREGS-1,
// snapshots each word and streams it out over valid/ready with its index.
//
// Build option: REGDUMP_SKIP_R0_EN - when defined register 0 is skipped (FIRST=1).
//
// Ports:
//   clk, reset      rising-edge clock, synchronous active-high reset
//   start           dump request, only honoured in IDLE
//   busy, done      busy in LOAD/SEND; done pulses one cycle after the last word
//   rf_addr/rf_data register file read port (combinational data)
//   out_valid/out_ready/out_data/out_index/out_last  word stream
module regfile_dump #(
    parameter int unsigned NREGS = 32,
    parameter int unsigned AW    = 5,
    parameter int unsigned DW    = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] rf_addr,
    input  logic [DW-1:0] rf_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [AW-1:0] out_index,
    output logic          out_last
);

`ifdef REGDUMP_SKIP_R0_EN
    localparam logic [AW-1:0] FIRST = AW'(1);
`else
    localparam logic [AW-1:0] FIRST = AW'(0);
`endif
    localparam logic [AW-1:0] LAST = AW'(NREGS - 1);

    typedef enum logic [1:0] {IDLE, LOAD, SEND, DONE} state_t;

    state_t        state;
    logic [AW-1:0] idx;

    // Single-process FSM; every output is a register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            idx       <= '0;
            rf_addr   <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_index <= '0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        idx     <= FIRST;
                        rf_addr <= FIRST;
                        busy    <= 1'b1;
                        state   <= LOAD;
                    end
                end
                LOAD: begin
                    // Per-word snapshot of the register addressed this cycle.
                    out_data  <= rf_data;
                    out_index <= idx;
                    out_last  <= (idx == LAST);
                    out_valid <= 1'b1;
                    state     <= SEND;
                end
                SEND: begin
                    // Everything holds while the consumer stalls.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (out_last) begin
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            rf_addr <= '0;
                            state   <= DONE;
                        end else begin
                            idx     <= idx + AW'(1);
                            rf_addr <= idx + AW'(1);
                            state   <= LOAD;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_dump.sv
// Testbench for regfile_dump: models the register file, drives dumps with
// directed and random back-pressure and checks the word stream and timing.
module tb_regfile_dump;

    localparam int NREGS = 32;
`ifdef REGDUMP_SKIP_R0_EN
    localparam int FIRST = 1;
`else
    localparam int FIRST = 0;
`endif
    localparam int NW = NREGS - FIRST;

    logic        clk;
    logic        reset;
    logic        start;
    logic        busy;
    logic        done;
    logic [4:0]  rf_addr;
    logic [31:0] rf_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [4:0]  out_index;
    logic        out_last;

    logic [31:0] regs [NREGS];

    int checks = 0;
    int passes = 0;

    assign rf_data = regs[rf_addr];

    regfile_dump #(.NREGS(NREGS), .AW(5), .DW(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .rf_addr   (rf_addr),
        .rf_data   (rf_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_index (out_index),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) passes++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One dump from IDLE. mode 0: ready high except a stall of stall_len cycles
    // on register stall_idx; mode 1: random ready. write_idx: when that word is
    // first presented, reg[30] is overwritten. reset_cyc > 0 aborts the dump.
    task automatic dump(input int mode, input int stall_idx, input int stall_len,
                        input bit hold_start, input int write_idx, input int reset_cyc,
                        output int done_cyc, output int nwords);
        int          cyc;
        int          k;
        int          stall_cnt;
        int          last_acc;
        bit          stalled;
        bit          seen;
        bit          written;
        logic [31:0] h_data;
        logic [4:0]  h_index;
        logic        h_last;
        logic [4:0]  h_addr;
        int          exp_idx;
        k = 0; stall_cnt = 0; last_acc = -10; stalled = 0; seen = 0; written = 0;
        h_data = '0; h_index = '0; h_last = 1'b0; h_addr = '0;
        done_cyc = -1;
        start = 1'b1;
        tick();
        cyc = 1;
        if (!hold_start) start = 1'b0;
        check("load_busy", 64'(busy), 64'd1);
        check("load_valid", 64'(out_valid), 64'd0);
        check("load_addr", 64'(rf_addr), 64'(FIRST));
        while (cyc < 600) begin
            if (reset_cyc == cyc) begin
                reset = 1'b1;
                tick();
                reset = 1'b0;
                check("rst_valid", 64'(out_valid), 64'd0);
                check("rst_busy", 64'(busy), 64'd0);
                check("rst_addr", 64'(rf_addr), 64'd0);
                check("rst_done", 64'(done), 64'd0);
                for (int i = 0; i < 5; i++) begin
                    tick();
                    check("rst_nodone", 64'(done), 64'd0);
                end
                nwords = k;
                return;
            end
            exp_idx = FIRST + k;
            if (out_valid) begin
                if (!seen) begin
                    check("first_valid_cyc", 64'(cyc), 64'd2);
                    seen = 1;
                end
                if (write_idx == exp_idx && !written) begin
                    regs[30] = 32'hDEADBEEF;
                    written = 1;
                end
                if (mode == 1) out_ready = 1'($urandom_range(0, 1));
                else if (exp_idx == stall_idx && stall_cnt < stall_len) begin
                    out_ready = 1'b0;
                    stall_cnt++;
                end else out_ready = 1'b1;
                if (stalled) begin
                    check("hold_data", 64'(out_data), 64'(h_data));
                    check("hold_index", 64'(out_index), 64'(h_index));
                    check("hold_last", 64'(out_last), 64'(h_last));
                    check("hold_addr", 64'(rf_addr), 64'(h_addr));
                end
                if (out_ready) begin
                    check("word_index", 64'(out_index), 64'(exp_idx));
                    check("word_data", 64'(out_data), 64'(regs[exp_idx]));
                    check("word_last", 64'(out_last), 64'(exp_idx == NREGS - 1));
                    if (exp_idx == 30 && written)
                        check("write_seen", 64'(out_data), 64'h0000_0000_DEAD_BEEF);
                    k++;
                    last_acc = cyc;
                    stalled = 0;
                end else begin
                    stalled = 1;
                    h_data = out_data; h_index = out_index; h_last = out_last; h_addr = rf_addr;
                end
            end else begin
                out_ready = 1'($urandom_range(0, 1));
                stalled = 0;
            end
            if (done) begin
                done_cyc = cyc;
                check("done_after_last", 64'(cyc), 64'(last_acc + 1));
                check("done_busy", 64'(busy), 64'd0);
                break;
            end
            tick();
            cyc++;
        end
        if (done_cyc < 0) check("dump_timeout", 64'(cyc), 64'd0);
        nwords = k;
        check("nwords", 64'(k), 64'(NW));
        tick();
        check("idle_done", 64'(done), 64'd0);
        check("idle_busy", 64'(busy), 64'd0);
        check("idle_addr", 64'(rf_addr), 64'd0);
    endtask

    initial begin
        int dc;
        int nw;
        clk = 1'b0;
        reset = 1'b1;
        start = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < NREGS; i++) regs[i] = 32'(i * 32'h1111_1111);
        tick();
        tick();
        reset = 1'b0;
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_valid", 64'(out_valid), 64'd0);
        check("reset_addr", 64'(rf_addr), 64'd0);
        check("reset_data", 64'(out_data), 64'd0);
        check("reset_index", 64'(out_index), 64'd0);
        check("reset_last", 64'(out_last), 64'd0);
        tick();

        // Full dump with ready always high.
        dump(0, -1, 0, 1'b0, -1, 0, dc, nw);
        check("done_cyc_plain", 64'(dc), 64'(2 * NW + 1));

        // Stall five cycles on word 7 with random register contents.
        for (int i = 0; i < NREGS; i++) regs[i] = $urandom;
        dump(0, 7, 5, 1'b0, -1, 0, dc, nw);
        check("done_cyc_stall", 64'(dc), 64'(2 * NW + 1 + 5));

        // Random back-pressure.
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < NREGS; i++) regs[i] = $urandom;
            dump(1, -1, 0, 1'b0, -1, 0, dc, nw);
        end

        // Start held through the dump and 3 cycles beyond: exactly one restart from IDLE.
        dump(0, -1, 0, 1'b1, -1, 0, dc, nw);
        check("done_cyc_hold", 64'(dc), 64'(2 * NW + 1));
        tick();
        check("restart_busy", 64'(busy), 64'd1);
        check("restart_addr", 64'(rf_addr), 64'(FIRST));
        tick();
        start = 1'b0;
        check("restart_valid", 64'(out_valid), 64'd1);
        check("restart_index", 64'(out_index), 64'(FIRST));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_busy", 64'(busy), 64'd0);
        tick();

        // Reset in cycle 20, then a fresh dump from the first register.
        dump(0, -1, 0, 1'b0, -1, 20, dc, nw);
        check("abort_no_done", 64'(dc), 64'hFFFF_FFFF_FFFF_FFFF);
        dump(0, -1, 0, 1'b0, -1, 0, dc, nw);
        check("done_cyc_after_rst", 64'(dc), 64'(2 * NW + 1));

        // Write reg[30] while word 10 is presented.
        for (int i = 0; i < NREGS; i++) regs[i] = $urandom;
        regs[30] = 32'h1234_5678;
        dump(0, -1, 0, 1'b0, 10, 0, dc, nw);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
